// File: rtl/dac_pkg.sv
// ------------------------------------------------------------------
// dac_pkg: shared DAC-path types, widths and saturating arithmetic
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

package dac_pkg;

  localparam int DAC_DW = 24;
  localparam int DAC_AW = 28;

  // Full scale (+2^(DW-1)) and the integrator clamp limits, held at sum width AW+2
  localparam logic signed [DAC_AW+1:0] DAC_FS =
    {{(DAC_AW+2-DAC_DW){1'b0}}, 1'b1, {(DAC_DW-1){1'b0}}};
  localparam logic signed [DAC_AW+1:0] DAC_SAT_MAX = {3'b000, {(DAC_AW-1){1'b1}}};
  localparam logic signed [DAC_AW+1:0] DAC_SAT_MIN = {3'b111, {(DAC_AW-1){1'b0}}};

  localparam logic [15:0] DAC_DITH_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUN     = 2'b01,
    ST_RECOVER = 2'b10
  } sdm_state_e;

  function automatic logic signed [DAC_AW-1:0] sat_add(
    input logic signed [DAC_AW+1:0] a,
    input logic signed [DAC_AW+1:0] b
  );
    logic signed [DAC_AW+1:0] s;
    s = a + b;
    if (s > DAC_SAT_MAX)      return DAC_SAT_MAX[DAC_AW-1:0];
    else if (s < DAC_SAT_MIN) return DAC_SAT_MIN[DAC_AW-1:0];
    else                      return s[DAC_AW-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/sdm2_lfsr_dither.sv
// ------------------------------------------------------------------
// sdm2_lfsr_dither: 16-bit Fibonacci LFSR mapped to a +1/-1 LSB dither
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

module sdm2_lfsr_dither
  import dac_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  output logic signed [1:0] dith_o
);

  logic [15:0] lfsr_q;
  logic        w_fb;

  // Taps 16,14,13,11 (1-based)
  assign w_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q <= DAC_DITH_SEED;
    end else if (en_i) begin
      lfsr_q <= {lfsr_q[14:0], w_fb};
    end
  end

  assign dith_o = lfsr_q[0] ? 2'sb01 : 2'sb11;

endmodule

`default_nettype wire

// File: rtl/sdm2_bitstream_mod.sv
// ------------------------------------------------------------------
// sdm2_bitstream_mod: 2nd-order 1-bit sigma-delta modulator with
// overload recovery and idle-tone suppression. Option: SDM2_DITHER_EN.
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

module sdm2_bitstream_mod
  import dac_pkg::*;
#(
  parameter int LIMIT   = 1 << 25,
  parameter int OVL_CNT = 4,
  parameter int IDLE_TO = 64
) (
  input  logic                     clock_up,
  input  logic                     rst,
  input  logic signed [DAC_DW-1:0] Data_in,
  input  logic                     in_valid,
  output logic                     dout,
  output logic                     dout_valid,
  output logic                     ovl_pulse,
  output logic [1:0]               state_o
);

  localparam int DW  = DAC_DW;
  localparam int AW  = DAC_AW;
  localparam int OCW = $clog2(OVL_CNT + 1);
  localparam int ICW = $clog2(IDLE_TO + 1);
  localparam logic [OCW-1:0] OVL_LAST  = OCW'(OVL_CNT - 1);
  localparam logic [ICW-1:0] IDLE_LAST = ICW'(IDLE_TO - 1);
  localparam logic [AW:0]    LIMIT_V   = (AW+1)'(LIMIT);

  sdm_state_e             state_q;
  logic signed [AW-1:0]   i1_q, i2_q, i1_d, i2_d;
  logic                   dout_q, dout_valid_q, ovl_pulse_q, rec_q;
  logic [OCW-1:0]         ovl_cnt_q;
  logic [ICW-1:0]         idle_cnt_q;

  logic signed [AW+1:0]   w_x, w_fb;
  logic [AW:0]            w_i2_ext, w_i2_mag;
  logic                   w_accept, w_ovl;

  assign w_accept = in_valid && (state_q != ST_RECOVER);

`ifdef SDM2_DITHER_EN
  logic signed [1:0] w_dith;

  sdm2_lfsr_dither u_dither (
    .clk_i  (clock_up),
    .rst_i  (rst),
    .en_i   (w_accept),
    .dith_o (w_dith)
  );

  assign w_x = (AW+2)'(Data_in) + (AW+2)'(w_dith);
`else
  assign w_x = (AW+2)'(Data_in);
`endif

  // The first sample out of IDLE always sees -FS, whatever the idle toggle left in dout_q
  assign w_fb = (state_q == ST_RUN && dout_q) ? DAC_FS : -DAC_FS;
  assign i1_d = sat_add((AW+2)'(i1_q) + w_x, -w_fb);
  assign i2_d = sat_add((AW+2)'(i2_q) + (AW+2)'(i1_d), -(w_fb <<< 1));

  assign w_i2_ext = {i2_d[AW-1], i2_d};
  assign w_i2_mag = i2_d[AW-1] ? (~w_i2_ext + 1'b1) : w_i2_ext;
  assign w_ovl    = w_i2_mag > LIMIT_V;

  always_ff @(posedge clock_up) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      i1_q         <= '0;
      i2_q         <= '0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      ovl_pulse_q  <= 1'b0;
      rec_q        <= 1'b0;
      ovl_cnt_q    <= '0;
      idle_cnt_q   <= '0;
    end else begin
      ovl_pulse_q <= 1'b0;
      if (w_accept) begin
        i1_q       <= i1_d;
        i2_q       <= i2_d;
        idle_cnt_q <= '0;
        if (w_ovl && ovl_cnt_q == OVL_LAST) begin
          state_q      <= ST_RECOVER;
          ovl_pulse_q  <= 1'b1;
          dout_q       <= 1'b0;
          dout_valid_q <= 1'b0;
          ovl_cnt_q    <= '0;
          rec_q        <= 1'b0;
        end else begin
          state_q      <= ST_RUN;
          dout_q       <= ~i2_d[AW-1];
          dout_valid_q <= 1'b1;
          ovl_cnt_q    <= w_ovl ? ovl_cnt_q + 1'b1 : '0;
        end
      end else begin
        dout_valid_q <= 1'b0;
        case (state_q)
          ST_IDLE: dout_q <= ~dout_q;
          ST_RUN: begin
            if (idle_cnt_q == IDLE_LAST) begin
              state_q    <= ST_IDLE;
              i1_q       <= '0;
              i2_q       <= '0;
              dout_q     <= 1'b0;
              idle_cnt_q <= '0;
              ovl_cnt_q  <= '0;
            end else begin
              idle_cnt_q <= idle_cnt_q + 1'b1;
            end
          end
          ST_RECOVER: begin
            i1_q   <= '0;
            i2_q   <= '0;
            dout_q <= 1'b0;
            rec_q  <= 1'b1;
            if (rec_q) begin
              state_q <= ST_RUN;
              rec_q   <= 1'b0;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign ovl_pulse  = ovl_pulse_q;
  assign state_o    = state_q;

endmodule

`default_nettype wire
